// File: rtl/selecting_machine_pkg.sv
// rtl/selecting_machine_pkg.sv - shared types and frame classifier for the keypad scanner
package selecting_machine_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        BLOCKED
    } commit_state_t;

    typedef logic [3:0] key_code_t;

    typedef struct packed {
        frame_class_t cls;
        key_code_t    key;
    } frame_info_t;

    // Frame bits are active-low returns; key is forced to 0 unless exactly one
    // key is down so that every NONE or MULTI frame compares equal to the next.
    function automatic frame_info_t classify(input logic [ROWS*COLS-1:0] frame);
        logic [ROWS*COLS-1:0] low;
        frame_info_t          info;
        low      = ~frame;
        info.key = '0;
        for (int i = ROWS*COLS-1; i >= 0; i--) begin
            if (low[i]) begin
                info.key = 4'(i);
            end
        end
        if (low == '0) begin
            info.cls = NONE;
        end else if ((low & (low - 16'd1)) != '0) begin
            info.cls = MULTI;
            info.key = '0;
        end else begin
            info.cls = SINGLE;
        end
        return info;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module scan_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap; the terminal count itself is the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/selecting_machine_keypad.sv
// rtl/selecting_machine_keypad.sv - 4x4 keypad row scanner with frame debounce and press reporting
module selecting_machine_keypad
    import selecting_machine_pkg::*;
#(
    parameter int SCAN_TICK       = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] scan_row,
    input  logic [3:0] ret_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

    logic [3:0]              col_s1;
    logic [3:0]              col_s2;
    logic                    tick;
    logic [1:0]              row_idx;
    logic [ROWS*COLS-1:0]    frame_reg;
    logic [ROWS*COLS-1:0]    frame_next;
    logic                    frame_end;
    frame_info_t             cur;
    frame_info_t             prev;
    logic [3:0]              stab_cnt;
    logic [3:0]              stab_next;
    logic                    stable;
    commit_state_t           state;
    commit_state_t           state_next;
    key_code_t               code_next;
    logic                    held_next;
    logic                    valid_next;

    // Column returns are asynchronous to clk; bring them in through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= ret_col;
            col_s2 <= col_s1;
        end
    end

    scan_tick_gen #(
        .DIV (SCAN_TICK)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Frame as it stands once this dwell's sample lands, so frame end sees all four rows.
    always_comb begin
        frame_next = frame_reg;
        frame_next[row_idx*COLS +: COLS] = col_s2;
    end

    assign frame_end = tick && (row_idx == 2'd3);
    assign cur       = classify(frame_next);

    // Sample at end of dwell, then move the row drive on; reset discards a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx   <= 2'd0;
            scan_row  <= 4'b1110;
            frame_reg <= '1;
        end else if (tick) begin
            row_idx   <= row_idx + 2'd1;
            scan_row  <= ~(4'b0001 << (row_idx + 2'd1));
            frame_reg <= frame_next;
        end
    end

    // Run length of identical frames, saturating at the debounce depth.
    always_comb begin
        stab_next = 4'd1;
        if (cur == prev) begin
            stab_next = (stab_cnt >= DF) ? DF : stab_cnt + 4'd1;
        end
    end

    assign stable = (stab_next == DF);

    // Remember the last classified frame and its run length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= 4'd0;
            prev     <= '{cls: NONE, key: 4'd0};
        end else if (frame_end) begin
            stab_cnt <= stab_next;
            prev     <= cur;
        end
    end

    // Commit state and the registered outputs it drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            key_code  <= code_next;
            key_held  <= held_next;
            key_valid <= valid_next;
        end
    end

    // Only a fresh press out of IDLE pulses; roll-over and un-blocking update silently.
    always_comb begin
        state_next = state;
        code_next  = key_code;
        held_next  = key_held;
        valid_next = 1'b0;
        if (frame_end && stable) begin
            case (cur.cls)
                NONE: begin
                    if (state != IDLE) begin
                        state_next = IDLE;
                        held_next  = 1'b0;
                    end
                end
                SINGLE: begin
                    if (state == IDLE) begin
                        valid_next = 1'b1;
                    end
                    if (state != PRESSED || cur.key != key_code) begin
                        state_next = PRESSED;
                        code_next  = cur.key;
                        held_next  = 1'b1;
                    end
                end
                MULTI: begin
                    if (state != BLOCKED) begin
                        state_next = BLOCKED;
                        held_next  = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    held_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selecting_machine_keypad.sv
// tb/tb_selecting_machine_keypad.sv - directed bench with a frame-level keypad model
module tb_selecting_machine_keypad;

    localparam int ST = 4;
    localparam int DF = 2;
    localparam int FR = 4 * ST;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  scan_row;
    logic [3:0]  ret_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int          vectors     = 0;
    int          miscompares = 0;
    int          dut_pulses  = 0;
    logic [3:0]  last_pulse_code = 4'd0;

    always #5 clk = ~clk;

    selecting_machine_keypad #(
        .SCAN_TICK       (ST),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_row  (scan_row),
        .ret_col   (ret_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Switch matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        ret_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!scan_row[r] && keys[4*r+c]) begin
                    ret_col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -1 = no key, 0..15 = single key, 16 = several keys.
    function automatic int sig_of(input logic [15:0] m);
        int s;
        s = -1;
        if ($countones(m) > 1) begin
            s = 16;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (m[i]) s = i;
            end
        end
        return s;
    endfunction

    // Frame-level reference: cycle n after reset release, frame ends every FR cycles.
    initial begin : compare
        int         n;
        int         run;
        int         prev_sig;
        int         com_sig;
        int         sig;
        logic [15:0] fkeys;
        logic [3:0] m_code;
        logic       m_held;
        logic       m_valid;
        logic [3:0] e_row;
        n = 0; run = 0; prev_sig = -1; com_sig = -1; fkeys = '0;
        m_code = 4'd0; m_held = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_valid = 1'b0;
            if (!rst_n) begin
                n = 0; run = 0; prev_sig = -1; com_sig = -1; fkeys = '0;
                m_code = 4'd0; m_held = 1'b0;
            end else begin
                n++;
                if (n % FR == FR / 2) fkeys = keys;
                if (n % FR == 0) begin
                    sig      = sig_of(fkeys);
                    run      = (sig == prev_sig) ? run + 1 : 1;
                    prev_sig = sig;
                    if (run >= DF && sig != com_sig) begin
                        if (sig >= 0 && sig < 16) begin
                            m_valid = (com_sig == -1);
                            m_code  = 4'(sig);
                            m_held  = 1'b1;
                        end else begin
                            m_held  = 1'b0;
                        end
                        com_sig = sig;
                    end
                end
            end
            if (key_valid) begin
                dut_pulses++;
                last_pulse_code = key_code;
            end
            e_row = 4'b1111;
            e_row[(n / ST) % 4] = 1'b0;
            check("scan_row",  int'(scan_row),  int'(e_row));
            check("key_valid", int'(key_valid), int'(m_valid));
            check("key_code",  int'(key_code),  int'(m_code));
            check("key_held",  int'(key_held),  int'(m_held));
        end
    end

    task automatic frames(input int count, input logic [15:0] mask);
        keys = mask;
        repeat (count * FR) @(negedge clk);
    endtask

    initial begin : stimulus
        int p0;
        #1 rst_n = 1'b0;
        #1;
        check("reset scan_row",  int'(scan_row),  4'b1110);
        check("reset key_code",  int'(key_code),  0);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_held",  int'(key_held),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle scan
        p0 = dut_pulses;
        frames(10, 16'h0000);
        check("idle pulses", dut_pulses - p0, 0);

        // clean press of key 6
        p0 = dut_pulses;
        frames(5, 16'h0040);
        check("press6 pulses", dut_pulses - p0, 1);
        check("press6 code",   int'(last_pulse_code), 6);
        check("press6 held",   int'(key_held), 1);
        frames(1, 16'h0000);
        check("release6 held after 1 frame", int'(key_held), 1);
        frames(1, 16'h0000);
        check("release6 held after 2 frames", int'(key_held), 0);
        check("release6 code holds", int'(key_code), 6);

        // bounce on key 9
        p0 = dut_pulses;
        frames(1, 16'h0200);
        frames(1, 16'h0000);
        frames(1, 16'h0200);
        frames(1, 16'h0000);
        check("bounce no pulse", dut_pulses - p0, 0);
        frames(1, 16'h0200);
        check("bounce 1 stable frame", dut_pulses - p0, 0);
        frames(1, 16'h0200);
        check("bounce pulses", dut_pulses - p0, 1);
        check("bounce code", int'(last_pulse_code), 9);
        frames(2, 16'h0000);

        // keys 0 and 5 together, then release key 0
        p0 = dut_pulses;
        frames(3, 16'h0021);
        check("multi held", int'(key_held), 0);
        check("multi code holds", int'(key_code), 9);
        frames(2, 16'h0020);
        check("unblock held", int'(key_held), 1);
        check("unblock code", int'(key_code), 5);
        check("multi/unblock pulses", dut_pulses - p0, 0);
        frames(2, 16'h0000);

        // roll-over 3 -> 12
        p0 = dut_pulses;
        frames(3, 16'h0008);
        check("roll press3 code", int'(key_code), 3);
        frames(3, 16'h1000);
        check("roll code", int'(key_code), 12);
        check("roll held", int'(key_held), 1);
        check("roll pulses", dut_pulses - p0, 1);
        check("roll pulse code", int'(last_pulse_code), 3);
        frames(2, 16'h0000);

        // async reset with key 15 committed
        p0 = dut_pulses;
        frames(3, 16'h8000);
        check("key15 pulses", dut_pulses - p0, 1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async scan_row",  int'(scan_row),  4'b1110);
        check("async key_code",  int'(key_code),  0);
        check("async key_valid", int'(key_valid), 0);
        check("async key_held",  int'(key_held),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = dut_pulses;
        frames(1, 16'h8000);
        check("post-reset frame1 pulses", dut_pulses - p0, 0);
        frames(1, 16'h8000);
        check("post-reset pulses", dut_pulses - p0, 1);
        check("post-reset code", int'(last_pulse_code), 15);
        check("post-reset held", int'(key_held), 1);
        frames(2, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
